// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared mode and state encodings for the serial add/subtract unit
//
// Contents:
//   MODE_SUB / MODE_ADD : operation select values for MODE
//   state_t             : controller states ST_IDLE / ST_RUN
package addsub_pkg;

  localparam logic MODE_SUB = 1'b0;
  localparam logic MODE_ADD = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/addsub_slice.sv
// rtl/addsub_slice.sv - combinational CHUNK-bit add/subtract with borrow/carry in and out
//
// Ports:
//   a, b  in  CHUNK  operand slices
//   mode  in  1      MODE_SUB: a-b-bin, MODE_ADD: a+b+bin
//   bin   in  1      borrow-in (sub) / carry-in (add)
//   d     out CHUNK  result slice
//   bout  out 1      borrow-out (sub) / carry-out (add)
module addsub_slice
  import addsub_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             mode,
  input  logic             bin,
  output logic [CHUNK-1:0] d,
  output logic             bout
);

  logic [CHUNK:0] sum;

  // One extra bit: for subtraction it goes to 1 exactly when a < b + bin,
  // which is the borrow; for addition it is the carry.
  always_comb begin
    sum = '0;
    if (mode == MODE_ADD)
      sum = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, bin};
    else
      sum = {1'b0, a} - {1'b0, b} - {{CHUNK{1'b0}}, bin};
  end

  assign d    = sum[CHUNK-1:0];
  assign bout = sum[CHUNK];

endmodule

// File: rtl/addsub_serial.sv
// rtl/addsub_serial.sv - multi-cycle WIDTH-bit add/subtract, CHUNK bits per clock, LSB first
//
// Ports:
//   CK     in  1      clock, rising edge
//   RES    in  1      asynchronous active-high reset
//   START  in  1      request, sampled only while BUSY=0
//   MODE   in  1      0 = A-B-BR_IN, 1 = A+B+BR_IN (latched with START)
//   A, B   in  WIDTH  operands (latched with START)
//   BR_IN  in  1      borrow/carry in (latched with START)
//   DIF    out WIDTH  result, updated only on completion
//   BOUT   out 1      borrow-out / carry-out
//   OVF    out 1      signed overflow
//   ZERO   out 1      DIF == 0
//   BUSY   out 1      operation in progress
//   DONE   out 1      one-cycle completion pulse
module addsub_serial
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             CK,
  input  logic             RES,
  input  logic             START,
  input  logic             MODE,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BR_IN,
  output logic [WIDTH-1:0] DIF,
  output logic             BOUT,
  output logic             OVF,
  output logic             ZERO,
  output logic             BUSY,
  output logic             DONE
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] K_LAST = CW'(NCHUNK - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             a_msb;
  logic             b_msb;
  logic             mode_q;
  logic             br_q;
  logic [CW-1:0]    k;

  logic [CHUNK-1:0] d;
  logic             bout_c;
  logic [WIDTH-1:0] res_next;
  logic             ovf_next;

  // Operands are shifted right each step, so the active chunk always sits in
  // the low CHUNK bits and the single slice instance sees chunk k.
  addsub_slice #(.CHUNK(CHUNK)) u_slice (
    .a    (a_sh[CHUNK-1:0]),
    .b    (b_sh[CHUNK-1:0]),
    .mode (mode_q),
    .bin  (br_q),
    .d    (d),
    .bout (bout_c)
  );

  // Result accumulates from the top; after NCHUNK steps chunk 0 is at the LSB.
  // Written as shifts so CHUNK == WIDTH needs no special case.
  assign res_next = (res_sh >> CHUNK) | (WIDTH'(d) << (WIDTH - CHUNK));

  // Operand sign bits are kept separately because the shift registers lose them.
  always_comb begin
    ovf_next = 1'b0;
    if (mode_q == MODE_ADD)
      ovf_next = (a_msb == b_msb) && (res_next[WIDTH-1] != a_msb);
    else
      ovf_next = (a_msb != b_msb) && (res_next[WIDTH-1] != a_msb);
  end

  always_ff @(posedge CK or posedge RES) begin
    if (RES) begin
      state  <= ST_IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      mode_q <= MODE_SUB;
      br_q   <= 1'b0;
      k      <= '0;
      DIF    <= '0;
      BOUT   <= 1'b0;
      OVF    <= 1'b0;
      ZERO   <= 1'b1;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (START) begin
            a_sh   <= A;
            b_sh   <= B;
            a_msb  <= A[WIDTH-1];
            b_msb  <= B[WIDTH-1];
            mode_q <= MODE;
            br_q   <= BR_IN;
            k      <= '0;
            BUSY   <= 1'b1;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          a_sh   <= a_sh >> CHUNK;
          b_sh   <= b_sh >> CHUNK;
          res_sh <= res_next;
          br_q   <= bout_c;
          k      <= k + 1'b1;
          if (k == K_LAST) begin
            DIF   <= res_next;
            BOUT  <= bout_c;
            OVF   <= ovf_next;
            ZERO  <= (res_next == '0);
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_serial.sv
// tb/tb_addsub_serial.sv - directed self-checking bench for addsub_serial at CHUNK 4, 16 and 1
module tb_addsub_serial;

  logic        clk;
  logic        rst;
  logic        start [3];
  logic        mode;
  logic [15:0] a;
  logic [15:0] b;
  logic        br_in;
  logic [15:0] dif   [3];
  logic        bout  [3];
  logic        ovf   [3];
  logic        zero  [3];
  logic        busy  [3];
  logic        done  [3];

  int n_checks;
  int n_fails;

  addsub_serial #(.WIDTH(16), .CHUNK(4)) dut_c4 (
    .CK(clk), .RES(rst), .START(start[0]), .MODE(mode), .A(a), .B(b), .BR_IN(br_in),
    .DIF(dif[0]), .BOUT(bout[0]), .OVF(ovf[0]), .ZERO(zero[0]), .BUSY(busy[0]), .DONE(done[0])
  );

  addsub_serial #(.WIDTH(16), .CHUNK(16)) dut_c16 (
    .CK(clk), .RES(rst), .START(start[1]), .MODE(mode), .A(a), .B(b), .BR_IN(br_in),
    .DIF(dif[1]), .BOUT(bout[1]), .OVF(ovf[1]), .ZERO(zero[1]), .BUSY(busy[1]), .DONE(done[1])
  );

  addsub_serial #(.WIDTH(16), .CHUNK(1)) dut_c1 (
    .CK(clk), .RES(rst), .START(start[2]), .MODE(mode), .A(a), .B(b), .BR_IN(br_in),
    .DIF(dif[2]), .BOUT(bout[2]), .OVF(ovf[2]), .ZERO(zero[2]), .BUSY(busy[2]), .DONE(done[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Launches one op on unit u, measures edges from the START edge to DONE,
  // and checks that DIF holds its old value while busy.
  task automatic run_op(input int u, input string tag, input logic m,
                        input logic [15:0] ia, input logic [15:0] ib, input logic ibr,
                        input int exp_lat, input logic [15:0] e_dif,
                        input logic e_bout, input logic e_ovf, input logic e_zero);
    int lat;
    logic [15:0] prev;
    logic got;
    prev = dif[u];
    got = 1'b0;
    mode = m; a = ia; b = ib; br_in = ibr; start[u] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start[u] = 1'b0;
    lat = 0;
    check_val({tag, "_busy_e0"}, 32'(busy[u]), 32'd1);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (done[u]) begin
        got = 1'b1;
        break;
      end
      if (busy[u] !== 1'b1 || dif[u] !== prev) begin
        check_val({tag, "_busy_hold"}, {15'd0, busy[u], dif[u]}, {15'd1, 1'b1, prev});
      end
    end
    check_val({tag, "_done_seen"}, 32'(got), 32'd1);
    check_val({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check_val({tag, "_dif"}, 32'(dif[u]), 32'(e_dif));
    check_val({tag, "_bout"}, 32'(bout[u]), 32'(e_bout));
    check_val({tag, "_ovf"}, 32'(ovf[u]), 32'(e_ovf));
    check_val({tag, "_zero"}, 32'(zero[u]), 32'(e_zero));
    check_val({tag, "_busy_end"}, 32'(busy[u]), 32'd0);
    @(negedge clk);
    check_val({tag, "_done_pulse"}, 32'(done[u]), 32'd0);
  endtask

  initial begin
    int n_done;
    n_checks = 0;
    n_fails  = 0;
    for (int i = 0; i < 3; i++) start[i] = 1'b0;
    mode = 1'b0; a = '0; b = '0; br_in = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check_val("rst_dif",  32'(dif[0]),  32'h0);
    check_val("rst_bout", 32'(bout[0]), 32'd0);
    check_val("rst_ovf",  32'(ovf[0]),  32'd0);
    check_val("rst_zero", 32'(zero[0]), 32'd1);
    check_val("rst_busy", 32'(busy[0]), 32'd0);
    check_val("rst_done", 32'(done[0]), 32'd0);

    // Scenarios 1-3 on the CHUNK=4 unit.
    run_op(0, "s1_sub",     1'b0, 16'd9,      16'd5,      1'b1, 4, 16'h0003, 1'b0, 1'b0, 1'b0);
    run_op(0, "s2_neg",     1'b0, 16'd5,      16'd9,      1'b0, 4, 16'hFFFC, 1'b1, 1'b0, 1'b0);
    run_op(0, "s2_ovf",     1'b0, 16'h8000,   16'h0001,   1'b0, 4, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    run_op(0, "s3_wrap",    1'b1, 16'hFFFF,   16'h0001,   1'b0, 4, 16'h0000, 1'b1, 1'b0, 1'b1);
    run_op(0, "s3_ovf",     1'b1, 16'h7FFF,   16'h0001,   1'b0, 4, 16'h8000, 1'b0, 1'b1, 1'b0);
    run_op(0, "s3_carryin", 1'b1, 16'h1234,   16'h4321,   1'b1, 4, 16'h5556, 1'b0, 1'b0, 1'b0);

    // Scenario 4: START held with new A during the op is ignored; START in DONE cycle accepted.
    mode = 1'b0; a = 16'd9; b = 16'd5; br_in = 1'b0; start[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = 16'h1234;
    repeat (3) @(negedge clk);
    start[0] = 1'b0;
    @(negedge clk);
    check_val("s4_done",      32'(done[0]), 32'd1);
    check_val("s4_dif",       32'(dif[0]),  32'h0004);
    mode = 1'b0; a = 16'h0010; b = 16'h0001; br_in = 1'b0; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    check_val("s4_b2b_busy",  32'(busy[0]), 32'd1);
    repeat (3) @(negedge clk);
    check_val("s4_b2b_early", 32'(done[0]), 32'd0);
    @(negedge clk);
    check_val("s4_b2b_done",  32'(done[0]), 32'd1);
    check_val("s4_b2b_dif",   32'(dif[0]),  32'h000F);

    // Scenario 5: asynchronous reset mid-op.
    mode = 1'b0; a = 16'd9; b = 16'd5; br_in = 1'b1; start[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_val("s5_busy", 32'(busy[0]), 32'd0);
    check_val("s5_dif",  32'(dif[0]),  32'h0);
    check_val("s5_zero", 32'(zero[0]), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    repeat (8) begin
      @(negedge clk);
      if (done[0]) n_done++;
    end
    check_val("s5_no_done", 32'(n_done), 32'd0);
    check_val("s5_idle",    32'(busy[0]), 32'd0);

    // Scenario 6: same op as scenario 1 on the full-width and bit-serial units.
    run_op(1, "s6_c16", 1'b0, 16'd9, 16'd5, 1'b1, 1,  16'h0003, 1'b0, 1'b0, 1'b0);
    run_op(2, "s6_c1",  1'b0, 16'd9, 16'd5, 1'b1, 16, 16'h0003, 1'b0, 1'b0, 1'b0);
    run_op(2, "s6_c1_neg", 1'b0, 16'd5, 16'd9, 1'b0, 16, 16'hFFFC, 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
